// File: rtl/sccb_rx_link_monitor.sv
`default_nettype none
// ============================================================================
// Module      : sccb_rx_link_monitor
// Description : Qualifies GTP RX link lock from K28.5 comma cadence on the
//               aligned 8b10b stream and forwards the stream with one cycle
//               of latency to the SCCB APB bridge.
//
// Ports       : clk            RX user clock (rxusrclk2), the only clock
//               rst            asynchronous, active-high reset
//               kchar_in[3:0]  per-byte K flag, bit n qualifies data_in[8n+7:8n]
//               data_in[31:0]  aligned RX word, lane 0 = first received byte
//               kchar_out      registered copy of kchar_in
//               data_out       registered copy of data_in
//               data_valid_out forwarded word is valid (link was up for it)
//               link_up        registered link state (bridge rx_ll_link_up)
//               lock_lost      one-cycle pulse on every UP->DOWN exit
//               comma_count    saturating good-comma count (stats build only)
//               err_count      saturating error-event count (stats build only)
//
// Build macro : SCCB_RX_LINK_STATS_EN enables the two statistics counters;
//               when undefined they are tied to zero.
//
// Revision    : 1.0 - initial release
// ============================================================================
module sccb_rx_link_monitor #(
    parameter int LOCK_COUNT    = 16,   // good commas to declare link up (2..65535)
    parameter int COMMA_TIMEOUT = 1024, // max cycles between good commas (4..65535)
    parameter int ERR_LIMIT     = 4     // misplaced commas while UP to drop (1..255)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  kchar_in,
    input  logic [31:0] data_in,
    output logic [3:0]  kchar_out,
    output logic [31:0] data_out,
    output logic        data_valid_out,
    output logic        link_up,
    output logic        lock_lost,
    output logic [15:0] comma_count,
    output logic [15:0] err_count
);

    localparam logic [7:0]  c_K28_5     = 8'hBC;
    localparam logic [15:0] c_LOCK_LAST = 16'(LOCK_COUNT - 1);
    localparam logic [15:0] c_GAP_MAX   = 16'(COMMA_TIMEOUT);
    // The timeout fires on the increment that lands on COMMA_TIMEOUT-1.
    localparam logic [15:0] c_GAP_TRIG  = 16'(COMMA_TIMEOUT - 2);
    localparam logic [7:0]  c_ERR_LAST  = 8'(ERR_LIMIT - 1);

    typedef enum logic [1:0] {
        ST_DOWN    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_UP      = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Word classification
    // ------------------------------------------------------------------
    logic [3:0] w_lane_comma;
    logic       w_misplaced;
    logic       w_good;
    logic       w_timeout;
    logic       w_err_event;

    for (genvar n = 0; n < 4; n++) begin : g_lane
        assign w_lane_comma[n] = kchar_in[n] && (data_in[8*n +: 8] == c_K28_5);
    end

    // A comma in any upper lane means the aligner has slipped; it overrides
    // a lane-0 comma in the same word.
    assign w_misplaced = |w_lane_comma[3:1];
    assign w_good      = w_lane_comma[0] && !w_misplaced;

    // ------------------------------------------------------------------
    // Comma gap counter
    // ------------------------------------------------------------------
    logic [15:0] r_gap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gap <= 16'd0;
        end else if (w_good) begin
            r_gap <= 16'd0;
        end else if (r_gap != c_GAP_MAX) begin
            r_gap <= r_gap + 16'd1;
        end
    end

    // Only one value of the counter triggers, and it passes through that
    // value once per expiry before holding at saturation.
    assign w_timeout   = !w_good && (r_gap == c_GAP_TRIG);
    assign w_err_event = w_misplaced || w_timeout;

    // ------------------------------------------------------------------
    // Link FSM
    // ------------------------------------------------------------------
    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_lock;
    logic [15:0] w_lock_next;
    logic [7:0]  r_errc;
    logic [7:0]  w_errc_next;
    logic        w_lost;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_DOWN;
            r_lock  <= 16'd0;
            r_errc  <= 8'd0;
        end else begin
            r_state <= w_state_next;
            r_lock  <= w_lock_next;
            r_errc  <= w_errc_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_lock_next  = r_lock;
        w_errc_next  = r_errc;
        w_lost       = 1'b0;
        case (r_state)
            ST_DOWN: begin
                w_lock_next = 16'd0;
                w_errc_next = 8'd0;
                if (w_good) begin
                    w_state_next = ST_ACQUIRE;
                    w_lock_next  = 16'd1;
                end
            end
            ST_ACQUIRE: begin
                if (w_err_event) begin
                    w_state_next = ST_DOWN;
                    w_lock_next  = 16'd0;
                end else if (w_good) begin
                    if (r_lock == c_LOCK_LAST) begin
                        w_state_next = ST_UP;
                        w_lock_next  = 16'd0;
                        w_errc_next  = 8'd0;
                    end else begin
                        w_lock_next = r_lock + 16'd1;
                    end
                end
            end
            ST_UP: begin
                // A timeout coinciding with a misplaced comma is a single
                // event; either way the link drops.
                if (w_timeout || (w_misplaced && (r_errc == c_ERR_LAST))) begin
                    w_state_next = ST_DOWN;
                    w_errc_next  = 8'd0;
                    w_lost       = 1'b1;
                end else if (w_misplaced) begin
                    w_errc_next = r_errc + 8'd1;
                end else if (w_good) begin
                    w_errc_next = 8'd0;
                end
            end
            default: begin
                w_state_next = ST_DOWN;
                w_lock_next  = 16'd0;
                w_errc_next  = 8'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and status outputs
    // ------------------------------------------------------------------
    logic [31:0] r_data;
    logic [3:0]  r_kchar;
    logic        r_valid;
    logic        r_lock_lost;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data      <= 32'd0;
            r_kchar     <= 4'd0;
            r_valid     <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            r_data      <= data_in;
            r_kchar     <= kchar_in;
            // Validity follows the state the word arrived in, so the word
            // that completes lock is itself not marked valid.
            r_valid     <= (r_state == ST_UP);
            r_lock_lost <= w_lost;
        end
    end

    assign data_out       = r_data;
    assign kchar_out      = r_kchar;
    assign data_valid_out = r_valid;
    assign link_up        = (r_state == ST_UP);
    assign lock_lost      = r_lock_lost;

    // ------------------------------------------------------------------
    // Optional statistics
    // ------------------------------------------------------------------
`ifdef SCCB_RX_LINK_STATS_EN
    logic [15:0] r_comma_cnt;
    logic [15:0] r_err_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_comma_cnt <= 16'd0;
            r_err_cnt   <= 16'd0;
        end else begin
            if (w_good && (r_comma_cnt != 16'hFFFF)) begin
                r_comma_cnt <= r_comma_cnt + 16'd1;
            end
            if (w_err_event && (r_err_cnt != 16'hFFFF)) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign comma_count = r_comma_cnt;
    assign err_count   = r_err_cnt;
`else
    assign comma_count = 16'd0;
    assign err_count   = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sccb_rx_link_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_sccb_rx_link_monitor
// Description : Directed self-checking bench for sccb_rx_link_monitor with
//               default parameters (LOCK_COUNT=16, COMMA_TIMEOUT=1024,
//               ERR_LIMIT=4). Inputs change 1 ns after the rising edge and
//               outputs are sampled 1 ns after the following rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sccb_rx_link_monitor;

`ifdef SCCB_RX_LINK_STATS_EN
    localparam bit c_STATS = 1'b1;
`else
    localparam bit c_STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  kchar_in;
    logic [31:0] data_in;
    logic [3:0]  kchar_out;
    logic [31:0] data_out;
    logic        data_valid_out;
    logic        link_up;
    logic        lock_lost;
    logic [15:0] comma_count;
    logic [15:0] err_count;

    int n_checks = 0;
    int n_fail   = 0;

    sccb_rx_link_monitor dut (
        .clk            (clk),
        .rst            (rst),
        .kchar_in       (kchar_in),
        .data_in        (data_in),
        .kchar_out      (kchar_out),
        .data_out       (data_out),
        .data_valid_out (data_valid_out),
        .link_up        (link_up),
        .lock_lost      (lock_lost),
        .comma_count    (comma_count),
        .err_count      (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic [3:0] k, input logic [31:0] d);
        kchar_in = k;
        data_in  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic comma();
        cyc(4'b0001, 32'h0000_00BC);
    endtask

    // BC byte without its K flag is ordinary data.
    task automatic plain();
        cyc(4'b0000, 32'h0000_BC00);
    endtask

    task automatic mis();
        cyc(4'b0100, 32'h00BC_0000);
    endtask

    initial begin
        rst      = 1'b1;
        kchar_in = 4'd0;
        data_in  = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_link_up",   32'(link_up), 32'd0);
        chk("rst_valid",     32'(data_valid_out), 32'd0);
        chk("rst_lock_lost", 32'(lock_lost), 32'd0);
        chk("rst_data_out",  data_out, 32'd0);
        chk("rst_kchar_out", 32'(kchar_out), 32'd0);
        chk("rst_comma_cnt", 32'(comma_count), 32'd0);
        chk("rst_err_cnt",   32'(err_count), 32'd0);
        rst = 1'b0;

        // Lock with a comma every 8 cycles.
        for (int i = 1; i <= 16; i++) begin
            comma();
            if (i == 15) chk("lock_pre16_down", 32'(link_up), 32'd0);
            if (i < 16) repeat (7) plain();
        end
        chk("lock_up",          32'(link_up), 32'd1);
        chk("lock_word_valid",  32'(data_valid_out), 32'd0);
        chk("lock_word_data",   data_out, 32'h0000_00BC);
        chk("lock_word_kchar",  32'(kchar_out), 32'd1);
        cyc(4'b0000, 32'hDEAD_BEEF);
        chk("next_word_valid",  32'(data_valid_out), 32'd1);
        chk("next_word_data",   data_out, 32'hDEAD_BEEF);
        chk("next_word_kchar",  32'(kchar_out), 32'd0);
        chk("lock_no_lost",     32'(lock_lost), 32'd0);

        // Timeout: link falls on the 1023rd plain word after the last comma.
        comma();
        repeat (1022) plain();
        chk("tmo_still_up",     32'(link_up), 32'd1);
        plain();
        chk("tmo_down",         32'(link_up), 32'd0);
        chk("tmo_lost_pulse",   32'(lock_lost), 32'd1);
        chk("tmo_err_cnt",      32'(err_count), c_STATS ? 32'd1 : 32'd0);
        plain();
        chk("tmo_lost_once",    32'(lock_lost), 32'd0);
        chk("tmo_valid_low",    32'(data_valid_out), 32'd0);

        // Misplaced commas while UP.
        for (int i = 0; i < 16; i++) begin
            comma();
            plain();
        end
        chk("mis_relock",       32'(link_up), 32'd1);
        repeat (3) mis();
        chk("mis_3_up",         32'(link_up), 32'd1);
        comma();
        repeat (3) mis();
        chk("mis_cleared_up",   32'(link_up), 32'd1);
        chk("mis_no_lost",      32'(lock_lost), 32'd0);
        mis();
        chk("mis_4_down",       32'(link_up), 32'd0);
        chk("mis_lost_pulse",   32'(lock_lost), 32'd1);
        chk("mis_err_cnt",      32'(err_count), c_STATS ? 32'd8 : 32'd0);

        // Acquire abort: lane-3 comma alongside a lane-0 comma is misplaced.
        for (int i = 0; i < 10; i++) begin
            comma();
            plain();
        end
        cyc(4'b1001, 32'hBC00_00BC);
        for (int i = 0; i < 6; i++) begin
            comma();
            plain();
        end
        chk("abort_held_down",  32'(link_up), 32'd0);
        for (int i = 0; i < 9; i++) begin
            comma();
            plain();
        end
        chk("abort_15_down",    32'(link_up), 32'd0);
        comma();
        chk("abort_16_up",      32'(link_up), 32'd1);
        chk("abort_no_lost",    32'(lock_lost), 32'd0);
        chk("abort_err_cnt",    32'(err_count), c_STATS ? 32'd9 : 32'd0);

        // Asynchronous reset while UP.
        cyc(4'b0000, 32'h1234_5678);
        chk("pre_rst_valid",    32'(data_valid_out), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_link_up",     32'(link_up), 32'd0);
        chk("arst_valid",       32'(data_valid_out), 32'd0);
        chk("arst_data_out",    data_out, 32'd0);
        chk("arst_lock_lost",   32'(lock_lost), 32'd0);
        chk("arst_err_cnt",     32'(err_count), 32'd0);
        @(posedge clk);
        #1;
        chk("arst_no_lost",     32'(lock_lost), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            comma();
            plain();
        end
        chk("arst_15_down",     32'(link_up), 32'd0);
        comma();
        chk("arst_16_up",       32'(link_up), 32'd1);

        // Comma every cycle: stats count saturates without wrapping.
        repeat (66000) comma();
        chk("sat_link_up",      32'(link_up), 32'd1);
        chk("sat_comma_cnt",    32'(comma_count), c_STATS ? 32'h0000_FFFF : 32'd0);
        chk("sat_err_cnt",      32'(err_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
